// File: rtl/gb_video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gb_video_pkg
// Description : Shared Game Boy video constants and the frame-capture state
//               encoding used by the capture controller and its bench.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package gb_video_pkg;

    // Native Game Boy LCD geometry and the frame-store address width
    localparam int GB_SCREEN_WIDTH  = 160;
    localparam int GB_SCREEN_HEIGHT = 144;
    localparam int FB_ADDR_W        = 15;

    // Capture sequencer states
    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        CAPTURE   = 2'd1,
        SWAP_PEND = 2'd2
    } capture_state_e;

endpackage : gb_video_pkg
`default_nettype wire

// File: rtl/gb_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : gb_edge_detect
// Description : Registers one input and emits registered single-cycle rise
//               and fall pulses.
// Ports       : clk     - clock, posedge
//               rst     - asynchronous active-high reset
//               i_sig   - monitored signal (already synchronous to clk)
//               o_rise  - one-cycle pulse after i_sig goes 0->1
//               o_fall  - one-cycle pulse after i_sig goes 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module gb_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev_q;
    logic r_rise_q;
    logic r_fall_q;
    logic w_rise_d;
    logic w_fall_d;

    always_comb begin
        w_rise_d = i_sig & ~r_prev_q;
        w_fall_d = ~i_sig & r_prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_q <= 1'b0;
            r_rise_q <= 1'b0;
            r_fall_q <= 1'b0;
        end else begin
            r_prev_q <= i_sig;
            r_rise_q <= w_rise_d;
            r_fall_q <= w_fall_d;
        end
    end

    assign o_rise = r_rise_q;
    assign o_fall = r_fall_q;

endmodule : gb_edge_detect
`default_nettype wire

// File: rtl/gb_frame_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gb_frame_capture_ctrl
// Description : Turns the Game Boy LCD pixel stream into back-buffer writes
//               for a double-buffered 160x144x2b frame store, and swaps the
//               front/back buffers only under a req/ack handshake with the
//               scan-out side so a displayed frame never tears.
// Ports       : clock      - system clock, posedge
//               reset      - asynchronous active-high reset
//               pixel_data - GB pixel shade, valid while data_latch is high
//               hsync      - GB line sync (active high)
//               vsync      - GB frame sync (active high)
//               data_latch - GB pixel strobe (active high)
//               swap_ack   - display grants the swap (level, synchronous)
//               wr_addr    - back-buffer write address
//               wr_data    - back-buffer write data
//               wr_en      - back-buffer write strobe, one cycle per pixel
//               front_sel  - 0: buffer1 front, 1: buffer2 front
//               swap_req   - swap request pending
//               frame_done - one-cycle pulse on a completed swap
//               drop_cnt   - dropped-frame count, saturating (stats build)
//               overrun    - sticky out-of-range latch flag (stats build)
// Build macro : GB_CAPTURE_STATS_EN adds drop_cnt and overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module gb_frame_capture_ctrl
    import gb_video_pkg::*;
#(
    parameter int GB_WIDTH  = GB_SCREEN_WIDTH,
    parameter int GB_HEIGHT = GB_SCREEN_HEIGHT,
    // 2**ADDR_W must cover GB_WIDTH*GB_HEIGHT
    parameter int ADDR_W    = FB_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        pixel_data,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              data_latch,
    input  logic              swap_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        wr_data,
    output logic              wr_en,
    output logic              front_sel,
    output logic              swap_req,
    output logic              frame_done
`ifdef GB_CAPTURE_STATS_EN
    ,
    output logic [7:0]        drop_cnt,
    output logic              overrun
`endif
);

    localparam logic [7:0]        c_pix_max   = 8'(GB_WIDTH);
    localparam logic [7:0]        c_line_max  = 8'(GB_HEIGHT);
    localparam logic [ADDR_W-1:0] c_line_step = ADDR_W'(GB_WIDTH);

    // ------------------------------------------------------------------
    // Edge detection on the GB sync/strobe pins
    // ------------------------------------------------------------------
    logic w_hs_rise;
    logic w_hs_fall;
    logic w_vs_rise;
    logic w_vs_fall;
    logic w_latch_rise;
    logic w_latch_fall;

    gb_edge_detect u_hsync_edge (
        .clk    (clock),
        .rst    (reset),
        .i_sig  (hsync),
        .o_rise (w_hs_rise),
        .o_fall (w_hs_fall)
    );

    gb_edge_detect u_vsync_edge (
        .clk    (clock),
        .rst    (reset),
        .i_sig  (vsync),
        .o_rise (w_vs_rise),
        .o_fall (w_vs_fall)
    );

    gb_edge_detect u_latch_edge (
        .clk    (clock),
        .rst    (reset),
        .i_sig  (data_latch),
        .o_rise (w_latch_rise),
        .o_fall (w_latch_fall)
    );

    // Only rising vsync/latch and falling hsync carry meaning here
    logic w_unused_edges;
    assign w_unused_edges = w_hs_rise ^ w_vs_fall ^ w_latch_fall;

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    capture_state_e    r_state_q,     w_state_d;
    logic [7:0]        r_pix_cnt_q,   w_pix_cnt_d;
    logic [7:0]        r_line_cnt_q,  w_line_cnt_d;
    logic [ADDR_W-1:0] r_line_base_q, w_line_base_d;
    logic [ADDR_W-1:0] r_wr_addr_q,   w_wr_addr_d;
    logic [1:0]        r_wr_data_q,   w_wr_data_d;
    logic              r_wr_en_q,     w_wr_en_d;
    logic              r_front_sel_q, w_front_sel_d;
    logic              r_swap_req_q,  w_swap_req_d;
    logic              r_frame_done_q, w_frame_done_d;
    logic [1:0]        r_pix_smp_q;
    logic              w_in_range;

    // The latch rise pulse is registered, so the pixel captured on the
    // edge that saw data_latch go high is the one held in r_pix_smp_q
    // while the pulse is visible to the sequencer.
    assign w_in_range = (r_pix_cnt_q < c_pix_max) && (r_line_cnt_q < c_line_max);

    always_comb begin
        w_state_d      = r_state_q;
        w_pix_cnt_d    = r_pix_cnt_q;
        w_line_cnt_d   = r_line_cnt_q;
        w_line_base_d  = r_line_base_q;
        w_wr_addr_d    = r_wr_addr_q;
        w_wr_data_d    = r_wr_data_q;
        w_wr_en_d      = 1'b0;
        w_front_sel_d  = r_front_sel_q;
        w_swap_req_d   = r_swap_req_q;
        w_frame_done_d = 1'b0;

        case (r_state_q)
            WAIT_SYNC: begin
                if (w_vs_rise) begin
                    w_pix_cnt_d   = 8'd0;
                    w_line_cnt_d  = 8'd0;
                    w_line_base_d = '0;
                    w_state_d     = CAPTURE;
                end
            end

            CAPTURE: begin
                if (w_latch_rise) begin
                    if (w_in_range) begin
                        w_wr_en_d   = 1'b1;
                        w_wr_addr_d = r_line_base_q + ADDR_W'(r_pix_cnt_q);
                        w_wr_data_d = r_pix_smp_q;
                    end
                    if (r_pix_cnt_q < c_pix_max) begin
                        w_pix_cnt_d = r_pix_cnt_q + 8'd1;
                    end
                end
                // Placed after the latch handling so a coincident write
                // uses the pre-increment line/pixel position.
                if (w_hs_fall) begin
                    w_pix_cnt_d = 8'd0;
                    if (r_line_cnt_q < c_line_max) begin
                        w_line_cnt_d  = r_line_cnt_q + 8'd1;
                        w_line_base_d = r_line_base_q + c_line_step;
                    end
                end
                if (w_vs_rise) begin
                    w_swap_req_d = 1'b1;
                    w_state_d    = SWAP_PEND;
                end
            end

            SWAP_PEND: begin
                w_swap_req_d = 1'b1;
                // Either a grant or the first pixel of the next frame ends
                // the wait; a pixel without a grant drops the finished frame
                // and overwrites the same back buffer from address 0.
                if (swap_ack || w_latch_rise) begin
                    w_swap_req_d  = 1'b0;
                    w_pix_cnt_d   = 8'd0;
                    w_line_cnt_d  = 8'd0;
                    w_line_base_d = '0;
                    w_state_d     = CAPTURE;
                    if (swap_ack) begin
                        w_front_sel_d  = ~r_front_sel_q;
                        w_frame_done_d = 1'b1;
                    end
                    if (w_latch_rise) begin
                        w_wr_en_d   = 1'b1;
                        w_wr_addr_d = '0;
                        w_wr_data_d = r_pix_smp_q;
                        w_pix_cnt_d = 8'd1;
                    end
                end
            end

            default: begin
                w_state_d = WAIT_SYNC;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q      <= WAIT_SYNC;
            r_pix_cnt_q    <= 8'd0;
            r_line_cnt_q   <= 8'd0;
            r_line_base_q  <= '0;
            r_wr_addr_q    <= '0;
            r_wr_data_q    <= 2'd0;
            r_wr_en_q      <= 1'b0;
            r_front_sel_q  <= 1'b0;
            r_swap_req_q   <= 1'b0;
            r_frame_done_q <= 1'b0;
            r_pix_smp_q    <= 2'd0;
        end else begin
            r_state_q      <= w_state_d;
            r_pix_cnt_q    <= w_pix_cnt_d;
            r_line_cnt_q   <= w_line_cnt_d;
            r_line_base_q  <= w_line_base_d;
            r_wr_addr_q    <= w_wr_addr_d;
            r_wr_data_q    <= w_wr_data_d;
            r_wr_en_q      <= w_wr_en_d;
            r_front_sel_q  <= w_front_sel_d;
            r_swap_req_q   <= w_swap_req_d;
            r_frame_done_q <= w_frame_done_d;
            r_pix_smp_q    <= pixel_data;
        end
    end

    assign wr_addr    = r_wr_addr_q;
    assign wr_data    = r_wr_data_q;
    assign wr_en      = r_wr_en_q;
    assign front_sel  = r_front_sel_q;
    assign swap_req   = r_swap_req_q;
    assign frame_done = r_frame_done_q;

`ifdef GB_CAPTURE_STATS_EN
    // ------------------------------------------------------------------
    // Capture statistics, cleared only by reset
    // ------------------------------------------------------------------
    logic [7:0] r_drop_cnt_q, w_drop_cnt_d;
    logic       r_overrun_q,  w_overrun_d;

    always_comb begin
        w_drop_cnt_d = r_drop_cnt_q;
        if ((r_state_q == SWAP_PEND) && w_latch_rise && !swap_ack &&
            (r_drop_cnt_q != 8'hFF)) begin
            w_drop_cnt_d = r_drop_cnt_q + 8'd1;
        end
        w_overrun_d = r_overrun_q |
                      ((r_state_q == CAPTURE) && w_latch_rise && !w_in_range);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop_cnt_q <= 8'd0;
            r_overrun_q  <= 1'b0;
        end else begin
            r_drop_cnt_q <= w_drop_cnt_d;
            r_overrun_q  <= w_overrun_d;
        end
    end

    assign drop_cnt = r_drop_cnt_q;
    assign overrun  = r_overrun_q;
`endif

endmodule : gb_frame_capture_ctrl
`default_nettype wire

// File: doc/gb_frame_capture_ctrl.md
Name: gb_frame_capture_ctrl

Overview:
- Sequences Game Boy LCD pixel-stream writes into the double-buffered 160x144 2-bit frame store.
- Detects edges on hsync, vsync and data_latch, and generates back-buffer write address, data and enable.
- Owns front/back buffer selection and swaps it only through a request/acknowledge handshake with the VGA scan-out side, so a swap never tears a displayed frame.
- Sits between the GB core video pins and the two frame_buffer RAMs, replacing ad-hoc counter and swap logic.

Parameters:
- GB_WIDTH, 160, active pixels per line.
- GB_HEIGHT, 144, active lines per frame.
- ADDR_W, 15, frame-buffer address width; must satisfy 2^ADDR_W >= GB_WIDTH*GB_HEIGHT.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- pixel_data  in  2  GB pixel shade, valid while data_latch is high.
- hsync  in  1  GB line sync, active high.
- vsync  in  1  GB frame sync, active high.
- data_latch  in  1  GB pixel strobe, active high.
- swap_ack  in  1  display side grants swap (level; high during VGA vblank, already synchronized to clock).
- wr_addr  out  ADDR_W  back-buffer write address.
- wr_data  out  2  back-buffer write data.
- wr_en  out  1  back-buffer write strobe, one cycle per pixel.
- front_sel  out  1  0: buffer1 is front (writes go to buffer2); 1: buffer2 is front (writes go to buffer1).
- swap_req  out  1  pending swap request.
- frame_done  out  1  one-cycle pulse on a completed swap.

Behaviour:
- Reset values: wr_addr=0, wr_data=0, wr_en=0, front_sel=0, swap_req=0, frame_done=0, state=WAIT_SYNC, all counters 0.
- Input sampling: hsync, vsync and data_latch are registered once (prev copies).
  - Rise = input high && prev low.
  - Fall = input low && prev high.
  - pixel_data is registered on the same edge that detects a latch rise.
- Counters:
  - pix_cnt: 8 bits.
  - line_cnt: 8 bits.
  - line_base: ADDR_W bits, equal to line_cnt*GB_WIDTH, maintained by adding GB_WIDTH. No multiplier.
- State WAIT_SYNC: ignore latch and hsync. On vsync rise, clear counters and go to CAPTURE.
- State CAPTURE:
  - Latch rise with pix_cnt<GB_WIDTH and line_cnt<GB_HEIGHT: next cycle wr_en=1, wr_addr=line_base+pix_cnt, wr_data=sampled pixel_data. pix_cnt then increments.
  - Latch rise out of range: no write. pix_cnt saturates at GB_WIDTH; the overrun condition is flagged.
  - hsync fall: pix_cnt=0. line_cnt+1 and line_base+GB_WIDTH, both saturating at GB_HEIGHT.
  - vsync rise: swap_req=1, go to SWAP_PEND.
- State SWAP_PEND:
  - swap_req is held high.
  - On swap_ack=1: front_sel toggles, swap_req=0, frame_done=1 for one cycle, counters clear, go to CAPTURE.
  - On a latch rise before ack, the frame is dropped: swap_req=0, no toggle, counters clear, the pixel is written to address 0 of the same back buffer, go to CAPTURE.
  - Ack and latch rise in the same cycle: the swap wins; the pixel is written to address 0 of the new back buffer.
- Latency: wr_en is asserted exactly 1 cycle after the clock edge at which the latch rise is detected, i.e. 2 cycles after data_latch first samples high.
- wr_en is never high for more than 1 cycle per latch rise.
- vsync rise during SWAP_PEND: ignored.
- hsync fall and latch rise in the same cycle: the write uses pre-increment counters; the reset/increment applies afterwards.
- Asynchronous reset mid-frame: immediate return to reset values; capture resumes only after the next vsync rise.

Optional Feature:
- Macro: GB_CAPTURE_STATS_EN.
- Defined: adds two outputs.
  - drop_cnt (8 bits): increments per dropped frame, saturates at 255.
  - overrun (1 bit): sticky flag, set by any out-of-range latch.
  - Both cleared only by reset.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package gb_video_pkg:
  - constants GB_SCREEN_WIDTH=160, GB_SCREEN_HEIGHT=144, FB_ADDR_W=15;
  - capture state encoding (WAIT_SYNC, CAPTURE, SWAP_PEND).
- Sub-module gb_edge_detect: registers one signal and emits rise/fall pulses. Instantiated 3 times.

Test Plan:
- Reset, then latch pulses with no vsync: wr_en stays 0, state WAIT_SYNC.
- vsync rise, then 160 latch pulses with pixel_data cycling 0..3, then hsync fall and 1 latch: addresses 0..159 with data i%4, then address 160; wr_en rises 1 cycle after each detected latch rise.
- Full 160x144 frame, then vsync rise with swap_ack=1 three cycles later: last address 23039; swap_req high 3 cycles; front_sel 0->1; frame_done one pulse.
- vsync rise with swap_ack held 0, then latch rise: swap_req drops, front_sel unchanged, write to address 0; drop_cnt=1 with GB_CAPTURE_STATS_EN defined.
- 165 latches on one line: only 160 writes; overrun=1 with stats enabled.
- Assert reset at line 70, pixel 40: all outputs are at reset values in the same cycle; after release and vsync, the first write goes to address 0.
